// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared MEM_OP encodings, FSM state and datapath widths
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef enum logic [3:0] {
        OP_NONE = 4'b0000,
        OP_LB   = 4'b0001,
        OP_LH   = 4'b0010,
        OP_LW   = 4'b0011,
        OP_LBU  = 4'b0100,
        OP_LHU  = 4'b0101,
        OP_SB   = 4'b1001,
        OP_SH   = 4'b1010,
        OP_SW   = 4'b1011
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with sign/zero extension
module load_align
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      a_i,
    input  logic [3:0]      mem_op_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{a_i, 3'b000} +: 8];
        half_v = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (mem_op_i)
            OP_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  data_o = {24'd0, byte_v};
            OP_LH:   data_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  data_o = {16'd0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory access stage, req/ack data port, writeback beat
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into flagged no-request beats.
module mem_access_stage
    import cpu_pkg::*;
(
    input  logic            CK_REF,
    input  logic            RST_N,
    input  logic            HALT,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] ALU_RESULT,
    input  logic [XLEN-1:0] STORE_DATA,
    input  logic [3:0]      MEM_OP,
    input  logic [RD_W-1:0] RD_IDX,
    input  logic            WB_EN,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [XLEN-1:0] DMEM_ADDR,
    output logic [3:0]      DMEM_BE,
    output logic [XLEN-1:0] DMEM_WDATA,
    input  logic            DMEM_ACK,
    input  logic [XLEN-1:0] DMEM_RDATA,
    output logic            OUT_VALID,
    output logic [XLEN-1:0] OUT_DATA,
    output logic [RD_W-1:0] OUT_RD,
    output logic            OUT_WB_EN,
    output logic            MISALIGN
);

    state_e            state_q;
    logic              req_q, we_q, ack_pend_q;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_pend_q;
    logic [3:0]        be_q, op_q;
    logic [1:0]        a_q;
    logic [RD_W-1:0]   rd_q;
    logic              wb_en_q;
    logic              out_valid_q, out_wb_en_q, misalign_q;
    logic [XLEN-1:0]   out_data_q;
    logic [RD_W-1:0]   out_rd_q;

    logic [1:0]        a_raw, a_d;
    logic              trap_d, mem_d;
    logic [3:0]        be_d;
    logic [XLEN-1:0]   wdata_d, load_data, rdata_sel;

    always_comb begin
        a_raw  = ALU_RESULT[1:0];
        mem_d  = is_load(MEM_OP) || is_store(MEM_OP);
        // Without the trap, misaligned low bits are silently cleared
        a_d    = is_word(MEM_OP) ? 2'b00 : is_half(MEM_OP) ? {a_raw[1], 1'b0} : a_raw;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_d = (is_half(MEM_OP) && a_raw[0]) || (is_word(MEM_OP) && (a_raw != 2'b00));
`else
        trap_d = 1'b0;
`endif
        case (MEM_OP)
            OP_SB: begin
                be_d    = 4'b0001 << a_d;
                wdata_d = {4{STORE_DATA[7:0]}};
            end
            OP_SH: begin
                be_d    = a_d[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{STORE_DATA[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = STORE_DATA;
            end
        endcase
    end

    assign rdata_sel = ack_pend_q ? rdata_pend_q : DMEM_RDATA;

    load_align u_load_align (
        .rdata_i  (rdata_sel),
        .a_i      (a_q),
        .mem_op_i (op_q),
        .data_o   (load_data)
    );

    always_ff @(posedge CK_REF) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            ack_pend_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_pend_q <= '0;
            be_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            rd_q         <= '0;
            wb_en_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_wb_en_q  <= 1'b0;
            misalign_q   <= 1'b0;
            out_data_q   <= '0;
            out_rd_q     <= '0;
        end else if (HALT) begin
            // Frozen, except an ack arriving now is banked so the request is not lost
            if (state_q == ST_WAIT && DMEM_ACK && !ack_pend_q) begin
                ack_pend_q   <= 1'b1;
                rdata_pend_q <= DMEM_RDATA;
                req_q        <= 1'b0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        if (mem_d && !trap_d) begin
                            state_q <= ST_WAIT;
                            req_q   <= 1'b1;
                            we_q    <= is_store(MEM_OP);
                            addr_q  <= {ALU_RESULT[XLEN-1:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            op_q    <= MEM_OP;
                            a_q     <= a_d;
                            rd_q    <= RD_IDX;
                            wb_en_q <= WB_EN;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= ALU_RESULT;
                            out_rd_q    <= RD_IDX;
                            out_wb_en_q <= WB_EN && !trap_d;
                            misalign_q  <= trap_d;
                        end
                    end
                end
                ST_WAIT: begin
                    if (DMEM_ACK || ack_pend_q) begin
                        state_q     <= ST_IDLE;
                        req_q       <= 1'b0;
                        ack_pend_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= we_q ? '0 : load_data;
                        out_rd_q    <= rd_q;
                        out_wb_en_q <= wb_en_q && !we_q;
                        misalign_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY   = RST_N && (state_q == ST_IDLE) && !HALT;
    assign DMEM_REQ   = req_q;
    assign DMEM_WE    = we_q;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_BE    = be_q;
    assign DMEM_WDATA = wdata_q;
    assign OUT_VALID  = out_valid_q;
    assign OUT_DATA   = out_data_q;
    assign OUT_RD     = out_rd_q;
    assign OUT_WB_EN  = out_wb_en_q;
    assign MISALIGN   = misalign_q;

endmodule
